// File: rtl/max_reduce_int16_stream.sv
// Streaming signed max/argmax reducer.
// Accepts one packet of signed elements (terminated by in_last) and returns
// one result beat holding the packet maximum, the index of its first
// occurrence, the element count and a sticky count-overflow flag.
//
// Handshake: a beat moves on either side only in a cycle where valid and
// ready are both high at the rising clock edge; valid/data are held by the
// sender until that happens, and ready never depends combinationally on valid.

// Signed greater-than comparator shared with the pairwise max datapath.
module gt_int_nbit #(
  parameter int WIDTH     = 16,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);

  if (IMPL_TYPE == 0) begin : g_direct
    // Native signed compare.
    assign gt = $signed(a) > $signed(b);
  end else begin : g_biased
    // Inverting the sign bits maps two's-complement order onto unsigned order.
    logic [WIDTH-1:0] a_biased;
    logic [WIDTH-1:0] b_biased;
    assign a_biased = {~a[WIDTH-1], a[WIDTH-2:0]};
    assign b_biased = {~b[WIDTH-1], b[WIDTH-2:0]};
    assign gt       = a_biased > b_biased;
  end

endmodule

module max_reduce_int16_stream #(
  parameter int WIDTH     = 16,
  parameter int IMPL_TYPE = 0,
  parameter int IDX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_max,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic [IDX_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q,     state_d;
  logic [WIDTH-1:0]     max_q,       max_d;
  logic [IDX_WIDTH-1:0] idx_q,       idx_d;
  logic [IDX_WIDTH-1:0] cnt_q,       cnt_d;
  logic                 ovf_q,       ovf_d;
  logic                 in_ready_q,  in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic in_xfer;
  logic out_xfer;
  logic gt;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  gt_int_nbit #(
    .WIDTH     (WIDTH),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_gt (
    .a  (in_data),
    .b  (max_q),
    .gt (gt)
  );

  // Next-state and running max/argmax/count update; everything holds by default.
  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          max_d   = in_data;
          idx_d   = '0;
          cnt_d   = IDX_WIDTH'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_xfer) begin
          // Strict greater-than: a tie keeps the earlier index.
          if (gt) begin
            max_d = in_data;
            idx_d = cnt_q;
          end
          cnt_d = cnt_q + IDX_WIDTH'(1);
          if (cnt_q == '1) begin
            ovf_d = 1'b1;
          end
          if (in_last) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_xfer) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Handshake outputs are registered from the next state so they align with it.
    in_ready_d  = (state_d != S_DONE);
    out_valid_d = (state_d == S_DONE);
  end

  // State, datapath and registered handshake flops; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      max_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_max_reduce_int16_stream.sv
// Testbench for max_reduce_int16_stream (IDX_WIDTH = 4 so count wrap is cheap to reach).
module tb_max_reduce_int16_stream;

  localparam int W  = 16;
  localparam int IW = 4;
  localparam int EW = W + IW + IW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_max;
  logic [IW-1:0] out_idx;
  logic [IW-1:0] out_count;
  logic          out_ovf;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int cyc    = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  int last_xfer_cyc = 0;

  logic [EW-1:0] exp_q[$];

  max_reduce_int16_stream #(
    .WIDTH     (W),
    .IMPL_TYPE (0),
    .IDX_WIDTH (IW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Packet result from its element list: first maximum, its index and the count,
  // with index/count reported modulo 2^IW and ovf when count exceeds 2^IW-1.
  function automatic logic [EW-1:0] model(input int vals[$]);
    int best;
    int best_i;
    int n;
    logic [W-1:0]  m;
    logic [IW-1:0] i4;
    logic [IW-1:0] c4;
    best   = vals[0];
    best_i = 0;
    n      = vals.size();
    for (int i = 1; i < n; i++) begin
      if (vals[i] > best) begin
        best   = vals[i];
        best_i = i;
      end
    end
    m  = W'(best);
    i4 = IW'(best_i % (1 << IW));
    c4 = IW'(n % (1 << IW));
    return {m, i4, c4, (n > (1 << IW) - 1)};
  endfunction

  // ---------------- scoreboard / output monitor ----------------
  // Drives out_ready and checks each accepted result beat against the queue head.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 9) < 7);
      default: out_ready = 1'b0;
    endcase
    if (!rst && out_valid && out_ready) begin
      beats++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got max=%0d idx=%0d cnt=%0d ovf=%0b, expected no beat",
                 $signed(out_max), out_idx, out_count, out_ovf);
      end else begin
        e = exp_q.pop_front();
        if ({out_max, out_idx, out_count, out_ovf} !== e) begin
          errors++;
          $display("FAIL result_beat: got max=%0d idx=%0d cnt=%0d ovf=%0b, expected max=%0d idx=%0d cnt=%0d ovf=%0b",
                   $signed(out_max), out_idx, out_count, out_ovf,
                   $signed(e[EW-1 -: W]), e[2*IW:IW+1], e[IW:1], e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one element; returns just after the edge on which it transferred.
  task automatic send_elem(input int v, input logic last);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = W'(v);
    in_last  = last;
    while (!in_ready) begin
      @(negedge clk);
      budget++;
      if (budget > 500) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: in_ready=%0b, expected 1 within 500 cycles", in_ready);
        return;
      end
    end
    @(posedge clk);
    #1;
    last_xfer_cyc = cyc;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Sends a packet with optional random in_valid bubbles; optionally queues its result.
  task automatic send_packet(input int vals[$], input int gap_pct, input bit expect_beat);
    if (expect_beat) exp_q.push_back(model(vals));
    for (int i = 0; i < vals.size(); i++) begin
      if (i > 0 && $urandom_range(0, 99) < gap_pct) idle_cycle();
      send_elem(vals[i], i == vals.size() - 1);
    end
    idle_cycle();
  endtask

  task automatic wait_beats(input int target);
    int budget;
    budget = 0;
    while (beats < target && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    checks++;
    if (beats < target) begin
      errors++;
      $display("FAIL beat_timeout: beats=%0d, expected %0d", beats, target);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_max, out_idx, out_count, out_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%0b vld=%0b max=%0d idx=%0d cnt=%0d ovf=%0b, expected all 0",
               in_ready, out_valid, out_max, out_idx, out_count, out_ovf);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: in_ready=%0b, expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_reset: in_ready=%0b out_valid=%0b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int first_cyc;
    int b0;
    b0 = beats;
    rdy_mode = 0;
    exp_q.push_back(model('{5, -3, 9, 2}));
    send_elem(5, 1'b0);
    first_cyc = last_xfer_cyc;
    send_elem(-3, 1'b0);
    send_elem(9, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: out_valid=%0b, expected 0", out_valid);
    end
    send_elem(2, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || (cyc - first_cyc) !== 3) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%0b span=%0d, expected 1 and 3", out_valid, cyc - first_cyc);
    end
    checks++;
    if (out_max !== 16'd9 || out_idx !== 4'd2 || out_count !== 4'd4 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_fields: max=%0d idx=%0d cnt=%0d ovf=%0b, expected 9 2 4 0",
               $signed(out_max), out_idx, out_count, out_ovf);
    end
    idle_cycle();
    wait_beats(b0 + 1);
  endtask

  task automatic test_extremes();
    int b0;
    b0 = beats;
    rdy_mode = 0;
    send_packet('{-32768, 32767, 32767, -1}, 0, 1'b1);
    send_packet('{-32768}, 0, 1'b1);
    send_packet('{-5, -5, -5}, 0, 1'b1);
    wait_beats(b0 + 3);
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] e;
    int budget;
    int b0;
    b0 = beats;
    rdy_mode = 2;
    e = model('{3, 11, -4});
    send_packet('{3, 11, -4}, 0, 1'b1);
    budget = 0;
    while (!out_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_max, out_idx, out_count, out_ovf} !== e) begin
        errors++;
        $display("FAIL backpressure_hold: vld=%0b rdy=%0b max=%0d idx=%0d cnt=%0d, expected 1 0 %0d %0d %0d",
                 out_valid, in_ready, $signed(out_max), out_idx, out_count,
                 $signed(e[EW-1 -: W]), e[2*IW:IW+1], e[IW:1]);
      end
    end
    rdy_mode = 0;
    wait_beats(b0 + 1);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%0b out_valid=%0b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int end1;
    int b0;
    b0 = beats;
    rdy_mode = 0;
    exp_q.push_back(model('{1, 2}));
    exp_q.push_back(model('{7, -7}));
    send_elem(1, 1'b0);
    send_elem(2, 1'b1);
    end1 = last_xfer_cyc;
    send_elem(7, 1'b0);
    checks++;
    if ((last_xfer_cyc - end1) !== 2) begin
      errors++;
      $display("FAIL b2b_gap: gap=%0d cycles, expected 2", last_xfer_cyc - end1);
    end
    idle_cycle();
    send_elem(-7, 1'b1);
    idle_cycle();
    wait_beats(b0 + 2);
    repeat (5) @(posedge clk);
    checks++;
    if (beats !== b0 + 2) begin
      errors++;
      $display("FAIL b2b_count: beats=%0d, expected %0d", beats - b0, 2);
    end
  endtask

  task automatic test_overflow();
    int vals[$];
    int b0;
    b0 = beats;
    rdy_mode = 0;
    vals = {};
    for (int i = 0; i < 17; i++) vals.push_back((i == 16) ? 1000 : i - 20);
    send_packet(vals, 0, 1'b1);
    wait_beats(b0 + 1);
  endtask

  task automatic test_reset_mid_packet();
    int b0;
    b0 = beats;
    rdy_mode = 0;
    send_elem(100, 1'b0);
    send_elem(200, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_max, out_idx, out_count, out_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_mid_packet: rdy=%0b vld=%0b max=%0d idx=%0d cnt=%0d ovf=%0b, expected all 0",
               in_ready, out_valid, out_max, out_idx, out_count, out_ovf);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_packet('{4, 8}, 0, 1'b1);
    wait_beats(b0 + 1);
  endtask

  task automatic test_random();
    int vals[$];
    int n;
    int b0;
    b0 = beats;
    rdy_mode = 1;
    for (int p = 0; p < 30; p++) begin
      vals = {};
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        if (p % 3 == 0) vals.push_back(int'($urandom_range(0, 3)) - 2);
        else            vals.push_back(int'($urandom_range(0, 65535)) - 32768);
      end
      send_packet(vals, 20, 1'b1);
    end
    wait_beats(b0 + 30);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid_packet();
    test_random();
    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: %0d results never arrived, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_reduce_int16_stream.md
# max_reduce_int16_stream

Streaming signed max/argmax reducer built on the team's `gt_int_nbit` comparator, with a valid/ready handshake on each side. It consumes a packet of signed WIDTH-bit elements, one per cycle, delimited by `in_last`, and keeps a running maximum and its index. It emits one result beat per packet: the maximum value, the index of its first occurrence, and the element count. It sits downstream of the element producer and reuses the same comparator the combinational pairwise max uses, so the PIM synthesis flow sees an identical compare datapath.

## Interface
- `WIDTH`, 16, element width; elements are two's-complement signed.
- `IMPL_TYPE`, 0, passed unchanged to the internal `gt_int_nbit` instance.
- `IDX_WIDTH`, 8, width of the index and count fields.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input element valid.
- `in_ready`  out  1  block can accept an element.
- `in_data`  in  WIDTH  signed element.
- `in_last`  in  1  marks the final element of the packet.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_max`  out  WIDTH  packet maximum.
- `out_idx`  out  IDX_WIDTH  zero-based index of the first occurrence of the maximum.
- `out_count`  out  IDX_WIDTH  number of elements in the packet, modulo 2^IDX_WIDTH.
- `out_ovf`  out  1  packet held more than 2^IDX_WIDTH − 1 elements; `out_idx` and `out_count` have wrapped.

## Operation
- **Handshake.**
  - An element transfers on a cycle where `in_valid && in_ready` is true.
  - The result transfers on a cycle where `out_valid && out_ready` is true.
- **States.** IDLE, ACCUM, DONE.
  - `in_ready` = 1 in IDLE and ACCUM, 0 in DONE.
  - `out_valid` = 1 only in DONE.
- **IDLE**, on an element transfer:
  - Load the running max with `in_data`, load the argmax index with 0, set the counter to 1, clear the overflow flag.
  - If `in_last` = 1, go to DONE; otherwise go to ACCUM.
- **ACCUM**, on an element transfer:
  - Compute `gt = gt_int_nbit(in_data, running max)`.
  - If `gt` = 1, the running max takes `in_data` and the argmax index takes the counter value. Ties keep the earlier index.
  - Increment the counter modulo 2^IDX_WIDTH. If it wraps to 0, set the sticky overflow flag.
  - If `in_last` = 1, go to DONE.
- **No transfer.** A cycle without a transfer in IDLE or ACCUM holds all state.
- **DONE.**
  - The outputs present the registered running max, argmax index, count and overflow flag. They stay stable while `out_ready` = 0.
  - On a result transfer, go to IDLE.
- **Arithmetic.** Comparison is signed, so −32768 is the smallest value and 32767 the largest. Values pass through without extension or truncation.
- **Result registers.** `out_max`, `out_idx`, `out_count` and `out_ovf` are driven directly from the state registers. Outside DONE they are don't-care for consumers but must still be deterministic: they show the current running state.

## Timing
- **Reset.** While `rst` is asserted:
  - The state is IDLE.
  - `in_ready` = 0 and `out_valid` = 0.
  - `out_max`, `out_idx`, `out_count` and `out_ovf` are all 0.
- **Leaving reset.** `in_ready` rises in the first cycle after `rst` deasserts.
- **Reset mid-packet or in DONE.** Asynchronous reset discards the partial or pending result immediately. No result beat is emitted for that packet.
- **Result latency.** `out_valid` rises in the cycle after the transfer of the element carrying `in_last`.
- **Throughput within a packet.** One element per cycle, with no bubbles.
- **Between packets.** There is at least one cycle with `in_ready` = 0 (DONE). If `out_ready` = 1 on DONE's first cycle, the next packet's first element can transfer on the following cycle, giving a one-bubble gap.
- **Simultaneous events.** No input transfer can coincide with an output transfer, because `in_ready` = 0 in DONE.
- **Producer rules.**
  - `in_valid` may drop between elements of a packet; state holds.
  - `in_data` and `in_last` must be stable while `in_valid` = 1 and `in_ready` = 0.

## Test plan
- **Basic packet.** Input 5, −3, 9, 2 (last on 2) with `out_ready` = 1 → one result beat 4 cycles after the first transfer: `out_max` = 9, `out_idx` = 2, `out_count` = 4, `out_ovf` = 0.
- **Signed extremes and ties.** Input −32768, 32767, 32767, −1 (last) → `out_max` = 32767, `out_idx` = 1 (tie keeps the earlier index). A single-element packet of −32768 → `out_max` = −32768, `out_idx` = 0, `out_count` = 1.
- **Backpressure.** Hold `out_ready` = 0 for 5 cycles after a packet → `out_valid` stays 1, outputs stay stable, `in_ready` stays 0. Raise `out_ready` → beat accepted, `in_ready` = 1 next cycle.
- **Back-to-back packets.** Input packets {1, 2} and {7, −7} with an idle `in_valid` bubble inside the second → results (2, idx 1, count 2) then (7, idx 0, count 2), each exactly once.
- **Overflow.** With `IDX_WIDTH` = 4, send 17 elements, max at element 16 → `out_count` = 1, `out_idx` = 0, `out_ovf` = 1.
- **Reset.** Assert `rst` after 2 elements of a packet → all outputs 0 immediately. The next full packet {4, 8} yields 8, idx 1, count 2, with no stale beat before it.
